// File: rtl/systolic_os_k_sequencer.sv
// K-loop sequencer for the output-stationary systolic array: buffers per-k operands,
// issues K framed step handshakes, then captures and presents the final psum matrix.
module systolic_os_k_sequencer #(
    parameter int M         = 8,
    parameter int N         = 8,
    parameter int DW        = 32,
    parameter int K_MAX     = 16,
    parameter int DRAIN_CYC = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         a_wr_en,
    input  logic [$clog2(K_MAX)-1:0]     a_wr_k,
    input  logic [M*DW-1:0]              a_wr_data,
    input  logic                         b_wr_en,
    input  logic [$clog2(K_MAX)-1:0]     b_wr_k,
    input  logic [N*DW-1:0]              b_wr_data,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [$clog2(K_MAX+1)-1:0]   cmd_k,
    input  logic                         cmd_acc,
    output logic                         step_valid,
    input  logic                         step_ready,
    output logic [M*DW-1:0]              a_row_flat,
    output logic [N*DW-1:0]              b_col_flat,
    output logic                         k_first,
    output logic                         k_last,
    input  logic [M*N*DW-1:0]            psum_in_flat,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [M*N*DW-1:0]            res_flat,
    output logic                         busy,
    output logic [$clog2(K_MAX+1)-1:0]   step_idx,
    output logic                         err
);

    localparam int KW  = $clog2(K_MAX);
    localparam int CW  = $clog2(K_MAX+1);
    localparam int DCW = $clog2(DRAIN_CYC+1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ISSUE   = 3'd1;
    localparam logic [2:0] WAIT_LO = 3'd2;
    localparam logic [2:0] WAIT_HI = 3'd3;
    localparam logic [2:0] DRAIN   = 3'd4;
    localparam logic [2:0] RESULT  = 3'd5;

    logic [2:0]      state;
    logic [CW-1:0]   k_lat;
    logic            acc_lat;
    logic [DCW-1:0]  drain_cnt;
    logic [M*DW-1:0] a_buf [K_MAX];
    logic [N*DW-1:0] b_buf [K_MAX];
    logic            a_wr_ok;
    logic            b_wr_ok;
    logic            cmd_ok;

    // A power-of-two depth makes every index representable, so no range check is needed.
    if (K_MAX == (1 << KW)) begin : g_full_idx
        assign a_wr_ok = 1'b1;
        assign b_wr_ok = 1'b1;
    end else begin : g_part_idx
        assign a_wr_ok = (a_wr_k < KW'(K_MAX));
        assign b_wr_ok = (b_wr_k < KW'(K_MAX));
    end

    assign cmd_ok = (cmd_k != '0) && (cmd_k <= CW'(K_MAX));
    assign busy   = (state != IDLE);

    // NOTE: the buffers are architecturally zero after reset, so the memory is cleared
    // explicitly here rather than left uninitialised as a plain RAM would be.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < K_MAX; k++) begin
                a_buf[k] <= '0;
                b_buf[k] <= '0;
            end
        end else begin
            if (a_wr_en && a_wr_ok) a_buf[a_wr_k] <= a_wr_data;
            if (b_wr_en && b_wr_ok) b_buf[b_wr_k] <= b_wr_data;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cmd_ready  <= 1'b0;
            k_lat      <= '0;
            acc_lat    <= 1'b0;
            step_idx   <= '0;
            drain_cnt  <= '0;
            step_valid <= 1'b0;
            k_first    <= 1'b0;
            k_last     <= 1'b0;
            a_row_flat <= '0;
            b_col_flat <= '0;
            res_valid  <= 1'b0;
            res_flat   <= '0;
            err        <= 1'b0;
        end else begin
            step_valid <= 1'b0;
            k_first    <= 1'b0;
            k_last     <= 1'b0;
            err        <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_ready && cmd_valid) begin
                        if (cmd_ok) begin
                            k_lat     <= cmd_k;
                            acc_lat   <= cmd_acc;
                            step_idx  <= '0;
                            cmd_ready <= 1'b0;
                            state     <= ISSUE;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (step_ready) begin
                        step_valid <= 1'b1;
                        a_row_flat <= a_buf[step_idx[KW-1:0]];
                        b_col_flat <= b_buf[step_idx[KW-1:0]];
                        k_first    <= (step_idx == '0) && !acc_lat;
                        k_last     <= (step_idx == k_lat - CW'(1));
                        state      <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (!step_ready) state <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (step_ready) begin
                        if (step_idx != k_lat - CW'(1)) begin
                            step_idx <= step_idx + CW'(1);
                            state    <= ISSUE;
                        end else begin
                            drain_cnt <= '0;
                            state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Lets the array's final accumulation settle before psum is sampled.
                    if (drain_cnt == DCW'(DRAIN_CYC-1)) begin
                        res_flat  <= psum_in_flat;
                        res_valid <= 1'b1;
                        state     <= RESULT;
                    end else begin
                        drain_cnt <= drain_cnt + DCW'(1);
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
